// File: rtl/proc_controller_p_if.sv
// proc_controller_p_if: control/status bundle between the sequencer and its datapath
interface proc_controller_p_if #(parameter int RF_ADDR_W = 4);
  localparam int A_W = 2 * RF_ADDR_W;
  localparam int IR_W = 4 + 4 * RF_ADDR_W;
  logic [IR_W-1:0] instruction;
  logic d_ready, alu_zero, go, step_mode;
  logic ld, pc_clr, pc_up, pc_load;
  logic [A_W-1:0] pc_target, d_addr, rf_imm;
  logic d_rd, d_wr;
  logic [1:0] rf_s;
  logic [RF_ADDR_W-1:0] rf_w_addr, rf_ra_addr, rf_rb_addr;
  logic rf_w_wr, rf_ra_rd, rf_rb_rd;
  logic [2:0] alu_s0;
  logic [3:0] state_o;
  logic halted, err;
  modport master (
    input instruction, d_ready, alu_zero, go, step_mode,
    output ld, pc_clr, pc_up, pc_load, pc_target, d_addr, d_rd, d_wr, rf_s, rf_imm,
    output rf_w_addr, rf_ra_addr, rf_rb_addr, rf_w_wr, rf_ra_rd, rf_rb_rd, alu_s0,
    output state_o, halted, err
  );
  modport slave (
    output instruction, d_ready, alu_zero, go, step_mode,
    input ld, pc_clr, pc_up, pc_load, pc_target, d_addr, d_rd, d_wr, rf_s, rf_imm,
    input rf_w_addr, rf_ra_addr, rf_rb_addr, rf_w_wr, rf_ra_rd, rf_rb_rd, alu_s0,
    input state_o, halted, err
  );
endinterface

// File: rtl/proc_controller_p.sv
// proc_controller_p: fetch/decode/execute sequencer for the eight-opcode datapath
module proc_controller_p #(
  parameter int RF_ADDR_W = 4,
  parameter int INIT_CYCLES = 2
) (
  input logic clock,
  input logic reset_n,
  proc_controller_p_if.master bus
);
  localparam int R = RF_ADDR_W;
  localparam int A_W = 2 * R;
  localparam int IR_W = 4 + 4 * R;
  localparam int T = IR_W - 5;
  localparam int CW = $clog2(INIT_CYCLES) + 1;
  typedef enum logic [3:0] {
    INIT = 4'd0, FETCH = 4'd1, DECODE = 4'd2, NOOP = 4'd3, LOAD_A = 4'd4, LOAD_B = 4'd5,
    STORE = 4'd6, ADD = 4'd7, SUB = 4'd8, HALT = 4'd9, LDI = 4'd10, JPZ_RD = 4'd11,
    JPZ_EX = 4'd12, PAUSE = 4'd13, ERROR = 4'd14
  } st_t;
  st_t st, dec, end_st;
  logic [CW-1:0] cnt;
  logic [3:0] op;
  logic [R-1:0] ra, rb, rw;
  logic [A_W-1:0] hi2, mid2;
  logic unused_lo;
  // Fields are packed from the MSB down after the opcode; the low R bits are spare.
  assign op = bus.instruction[IR_W-1 -: 4];
  assign ra = bus.instruction[T -: R];
  assign rb = bus.instruction[T-R -: R];
  assign rw = bus.instruction[T-2*R -: R];
  assign hi2 = bus.instruction[T -: A_W];
  assign mid2 = bus.instruction[T-R -: A_W];
  assign unused_lo = ^bus.instruction[R-1:0];
  assign end_st = bus.step_mode ? PAUSE : FETCH;
  always_comb begin
    dec = ERROR;
    case (op)
      4'd0: dec = NOOP;
      4'd1: dec = STORE;
      4'd2: dec = LOAD_A;
      4'd3: dec = ADD;
      4'd4: dec = SUB;
      4'd5: dec = HALT;
      4'd6: dec = LDI;
      4'd7: dec = JPZ_RD;
      default: dec = ERROR;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st <= INIT;
      cnt <= '0;
    end else begin
      case (st)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(INIT_CYCLES - 1)) st <= FETCH;
        end
        FETCH: st <= DECODE;
        DECODE: st <= dec;
        NOOP, ADD, SUB, LDI, LOAD_B, JPZ_EX: st <= end_st;
        JPZ_RD: st <= JPZ_EX;
        LOAD_A: if (bus.d_ready) st <= LOAD_B;
        STORE: if (bus.d_ready) st <= end_st;
        HALT, PAUSE: if (bus.go) st <= FETCH;
        default: st <= st;
      endcase
    end
  end
  assign bus.state_o = st;
  assign bus.pc_clr = st == INIT;
  assign bus.ld = st == FETCH;
  assign bus.pc_up = st == FETCH;
  assign bus.pc_load = st == JPZ_EX && bus.alu_zero;
  assign bus.pc_target = st == JPZ_EX ? mid2 : '0;
  assign bus.d_rd = st == LOAD_A;
  assign bus.d_wr = st == STORE;
  assign bus.d_addr = st == LOAD_A ? hi2 : st == STORE ? mid2 : '0;
  assign bus.rf_s = (st == LOAD_A || st == LOAD_B) ? 2'd1 : st == LDI ? 2'd2 : 2'd0;
  assign bus.rf_imm = st == LDI ? hi2 : '0;
  assign bus.rf_w_wr = st == ADD || st == SUB || st == LOAD_B || st == LDI;
  assign bus.rf_w_addr = bus.rf_w_wr ? rw : '0;
  assign bus.rf_ra_rd = st == ADD || st == SUB || st == STORE || st == JPZ_RD || st == JPZ_EX;
  assign bus.rf_ra_addr = bus.rf_ra_rd ? ra : '0;
  assign bus.rf_rb_rd = st == ADD || st == SUB;
  assign bus.rf_rb_addr = bus.rf_rb_rd ? rb : '0;
  assign bus.alu_s0 = st == ADD ? 3'd1 : st == SUB ? 3'd2 : (st == JPZ_RD || st == JPZ_EX) ? 3'd3 : 3'd0;
  assign bus.halted = st == HALT;
  assign bus.err = st == ERROR;
endmodule

// File: tb/tb_proc_controller_p.sv
// tb_proc_controller_p: cycle-by-cycle vector table plus reset corner sequences
module tb_proc_controller_p;
  logic clock = 0;
  logic reset_n = 0;
  int checks = 0;
  int failures = 0;
  always #5 clock = ~clock;
  proc_controller_p_if #(.RF_ADDR_W(4)) bus ();
  proc_controller_p #(.RF_ADDR_W(4), .INIT_CYCLES(2)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  typedef struct packed {
    logic [3:0] st;
    logic ld, pc_clr, pc_up, pc_load;
    logic [7:0] pc_target, d_addr;
    logic d_rd, d_wr;
    logic [1:0] rf_s;
    logic [7:0] rf_imm;
    logic [3:0] wa, ra, rb;
    logic w_wr, ra_rd, rb_rd;
    logic [2:0] alu;
    logic halted, err;
  } out_t;
  typedef struct {
    logic [19:0] instr;
    logic [3:0] ctl;
    out_t e;
  } vec_t;
  localparam logic [19:0] I_LD = 20'h2A530, I_ADD = 20'h31240, I_SUB = 20'h41240,
    I_ST = 20'h15C30, I_JZ = 20'h753C0, I_NOP = 20'h00000, I_LDI = 20'h67F90,
    I_HLT = 20'h50000, I_BAD = 20'hA0000;
  localparam logic [3:0] C = 4'b1000;
  out_t obs;
  vec_t vq[$];
  assign obs = {bus.state_o, bus.ld, bus.pc_clr, bus.pc_up, bus.pc_load, bus.pc_target,
    bus.d_addr, bus.d_rd, bus.d_wr, bus.rf_s, bus.rf_imm, bus.rf_w_addr, bus.rf_ra_addr,
    bus.rf_rb_addr, bus.rf_w_wr, bus.rf_ra_rd, bus.rf_rb_rd, bus.alu_s0, bus.halted, bus.err};
  task automatic add(input logic [19:0] i, input logic [3:0] ctl, input out_t e);
    vq.push_back('{i, ctl, e});
  endtask
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  out_t fe, ini, dc;
  initial begin
    ini = out_t'{st: 4'd0, pc_clr: 1'b1, default: '0};
    fe = out_t'{st: 4'd1, ld: 1'b1, pc_up: 1'b1, default: '0};
    dc = out_t'{st: 4'd2, default: '0};
    add(I_LD, C, ini);
    add(I_LD, C, ini);
    add(I_LD, C, fe);
    add(I_LD, C, dc);
    add(I_LD, 4'b0000, out_t'{st: 4'd4, d_addr: 8'hA5, d_rd: 1'b1, rf_s: 2'd1, default: '0});
    add(I_LD, 4'b0000, out_t'{st: 4'd4, d_addr: 8'hA5, d_rd: 1'b1, rf_s: 2'd1, default: '0});
    add(I_LD, C, out_t'{st: 4'd4, d_addr: 8'hA5, d_rd: 1'b1, rf_s: 2'd1, default: '0});
    add(I_LD, 4'b0000, out_t'{st: 4'd5, rf_s: 2'd1, w_wr: 1'b1, wa: 4'd3, default: '0});
    add(I_ADD, C, fe);
    add(I_ADD, C, dc);
    add(I_ADD, C, out_t'{st: 4'd7, ra: 4'd1, rb: 4'd2, wa: 4'd4, w_wr: 1'b1, ra_rd: 1'b1, rb_rd: 1'b1, alu: 3'd1, default: '0});
    add(I_SUB, C, fe);
    add(I_SUB, C, dc);
    add(I_SUB, C, out_t'{st: 4'd8, ra: 4'd1, rb: 4'd2, wa: 4'd4, w_wr: 1'b1, ra_rd: 1'b1, rb_rd: 1'b1, alu: 3'd2, default: '0});
    add(I_ST, C, fe);
    add(I_ST, C, dc);
    add(I_ST, 4'b0000, out_t'{st: 4'd6, d_addr: 8'hC3, d_wr: 1'b1, ra: 4'd5, ra_rd: 1'b1, default: '0});
    add(I_ST, C, out_t'{st: 4'd6, d_addr: 8'hC3, d_wr: 1'b1, ra: 4'd5, ra_rd: 1'b1, default: '0});
    add(I_JZ, C, fe);
    add(I_JZ, C, dc);
    add(I_JZ, C, out_t'{st: 4'd11, ra: 4'd5, ra_rd: 1'b1, alu: 3'd3, default: '0});
    add(I_JZ, 4'b1100, out_t'{st: 4'd12, ra: 4'd5, ra_rd: 1'b1, alu: 3'd3, pc_target: 8'h3C, pc_load: 1'b1, default: '0});
    add(I_JZ, C, fe);
    add(I_JZ, C, dc);
    add(I_JZ, C, out_t'{st: 4'd11, ra: 4'd5, ra_rd: 1'b1, alu: 3'd3, default: '0});
    add(I_JZ, C, out_t'{st: 4'd12, ra: 4'd5, ra_rd: 1'b1, alu: 3'd3, pc_target: 8'h3C, default: '0});
    add(I_NOP, C, fe);
    add(I_NOP, C, dc);
    add(I_NOP, C, out_t'{st: 4'd3, default: '0});
    add(I_LDI, C, fe);
    add(I_LDI, C, dc);
    add(I_LDI, 4'b1001, out_t'{st: 4'd10, rf_s: 2'd2, rf_imm: 8'h7F, wa: 4'd9, w_wr: 1'b1, default: '0});
    add(I_LDI, C, out_t'{st: 4'd13, default: '0});
    add(I_LDI, C, out_t'{st: 4'd13, default: '0});
    add(I_NOP, 4'b1010, out_t'{st: 4'd13, default: '0});
    add(I_NOP, 4'b1011, fe);
    add(I_NOP, 4'b1011, dc);
    add(I_NOP, 4'b1011, out_t'{st: 4'd3, default: '0});
    add(I_NOP, 4'b1010, out_t'{st: 4'd13, default: '0});
    add(I_HLT, C, fe);
    add(I_HLT, C, dc);
    add(I_HLT, C, out_t'{st: 4'd9, halted: 1'b1, default: '0});
    add(I_HLT, 4'b1010, out_t'{st: 4'd9, halted: 1'b1, default: '0});
    add(I_BAD, C, fe);
    add(I_BAD, C, dc);
    add(I_BAD, C, out_t'{st: 4'd14, err: 1'b1, default: '0});
    add(I_BAD, 4'b1010, out_t'{st: 4'd14, err: 1'b1, default: '0});
    add(I_BAD, 4'b1010, out_t'{st: 4'd14, err: 1'b1, default: '0});
    bus.instruction = '0;
    {bus.d_ready, bus.alu_zero, bus.go, bus.step_mode} = 4'b0;
    repeat (3) cyc();
    reset_n = 1;
    for (int k = 0; k < vq.size(); k++) begin
      bus.instruction = vq[k].instr;
      {bus.d_ready, bus.alu_zero, bus.go, bus.step_mode} = vq[k].ctl;
      #1;
      chk($sformatf("row%0d", k), 64'(obs), 64'(vq[k].e));
      cyc();
    end
    reset_n = 0;
    #1;
    chk("err_reset_state", 64'(bus.state_o), 64'd0);
    chk("err_reset_err", 64'(bus.err), 64'd0);
    chk("err_reset_pcclr", 64'(bus.pc_clr), 64'd1);
    bus.instruction = I_ADD;
    {bus.d_ready, bus.alu_zero, bus.go, bus.step_mode} = C;
    reset_n = 1;
    cyc();
    chk("init_hold", 64'({bus.state_o, bus.pc_clr, bus.ld}), 64'({4'd0, 1'b1, 1'b0}));
    cyc();
    chk("first_fetch", 64'({bus.state_o, bus.pc_clr, bus.ld, bus.pc_up}), 64'({4'd1, 1'b0, 1'b1, 1'b1}));
    cyc();
    cyc();
    chk("add_live", 64'({bus.state_o, bus.rf_w_wr}), 64'({4'd7, 1'b1}));
    #2 reset_n = 0;
    #1;
    chk("midadd_state", 64'(bus.state_o), 64'd0);
    chk("midadd_pcclr", 64'(bus.pc_clr), 64'd1);
    chk("midadd_wwr", 64'({bus.rf_w_wr, bus.alu_s0}), 64'd0);
    cyc();
    bus.instruction = I_LD;
    bus.d_ready = 0;
    reset_n = 1;
    repeat (4) cyc();
    chk("load_wait", 64'({bus.state_o, bus.d_rd, bus.d_addr}), 64'({4'd4, 1'b1, 8'hA5}));
    reset_n = 0;
    #1;
    chk("midload_drop", 64'({bus.state_o, bus.d_rd, bus.d_addr, bus.pc_clr}), 64'({4'd0, 1'b0, 8'h00, 1'b1}));
    reset_n = 1;
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/proc_controller_p.md
# proc_controller_p

Parametrised successor to the processor control FSM. Sequences fetch/decode/execute for an eight-opcode instruction set and drives the PC, instruction register, data RAM, register file, input mux and ALU of the datapath. Adds several capabilities over the previous generation: configurable register/address widths, data-RAM ready handshake, load-immediate, jump-if-zero, single-step mode, HALT resume, and a sticky illegal-opcode trap.

## Interface
- RF_ADDR_W, 4: register-file address width; derived A_W = 2*RF_ADDR_W (data/PC address), IR_W = 4 + 4*RF_ADDR_W
- INIT_CYCLES, 2: cycles pc_clr is held in INIT (≥1)
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- instruction  in  IR_W  current IR contents; op = [IR_W-1:IR_W-4]
- d_ready  in  1  data RAM completed the requested read/write this cycle
- alu_zero  in  1  ALU result == 0
- go  in  1  resume pulse (HALT, PAUSE)
- step_mode  in  1  1 = pause after every instruction
- ld, pc_clr, pc_up, pc_load  out  1  IR load, PC clear, PC increment, PC parallel load
- pc_target  out  A_W  PC load value
- d_addr  out  A_W;  d_rd, d_wr  out  1  data RAM address and strobes
- rf_s  out  2  write mux: 0 ALU, 1 RAM, 2 immediate
- rf_imm  out  A_W  immediate value
- rf_w_addr, rf_ra_addr, rf_rb_addr  out  RF_ADDR_W;  rf_w_wr, rf_ra_rd, rf_rb_rd  out  1
- alu_s0  out  3  0 none, 1 ADD, 2 SUB, 3 PASS_A
- state_o  out  4  current state code
- halted, err  out  1  in HALT / in ERROR

## Operation
- Outputs are Moore: decoded from current state plus instruction fields; unlisted outputs are 0 in every state.
- Field layout (R = RF_ADDR_W): LOAD op|addr(2R)|rw(R); STORE op|ra(R)|addr(2R)|-(R); ADD/SUB op|ra|rb|rw|-(R); LDI op|imm(2R)|rw; JPZ op|ra|target(2R)|-(R).
- Opcodes: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT, 6 LDI, 7 JPZ; 8–15 illegal.
- States/codes: INIT0 FETCH1 DECODE2 NOOP3 LOAD_A4 LOAD_B5 STORE6 ADD7 SUB8 HALT9 LDI10 JPZ_RD11 JPZ_EX12 PAUSE13 ERROR14.
- INIT: pc_clr=1; after INIT_CYCLES cycles go to FETCH.
- FETCH: ld=1, pc_up=1 → DECODE. DECODE: no strobes; branch on op; illegal → ERROR.
- NOOP → END. ADD/SUB: ra/rb/rw driven, rf_ra_rd=rf_rb_rd=rf_w_wr=1, rf_s=0, alu_s0=1/2 → END.
- LOAD_A: d_addr, d_rd=1, rf_s=1; stays until d_ready=1 → LOAD_B. LOAD_B: rf_s=1, rf_w_wr=1, rf_w_addr=rw → END.
- STORE: d_addr, rf_ra_addr=ra, rf_ra_rd=1, d_wr=1; stays until d_ready=1 → END.
- LDI: rf_s=2, rf_imm=imm, rf_w_wr=1 → END.
- JPZ_RD: rf_ra_rd=1, alu_s0=3 → JPZ_EX. JPZ_EX: rf_ra_rd=1, alu_s0=3; pc_target=target; pc_load=alu_zero → END.
- HALT: halted=1; go=1 → FETCH.
- END means PAUSE when step_mode=1, else FETCH. PAUSE: go=1 → FETCH.
- ERROR: err=1; held until reset_n asserted. go is ignored.
- pc_up and pc_load are never both 1. d_rd and d_wr are never both 1.

## Timing
- reset_n low: state becomes INIT immediately, mid-instruction included. Outputs then: pc_clr=1, state_o=0, everything else 0. Pending RAM strobes drop without waiting for d_ready.
- First FETCH occurs INIT_CYCLES edges after reset_n deasserts.
- Cycles per instruction with zero wait and step_mode=0 (FETCH through last execute state): NOOP/ADD/SUB/STORE/LDI 3, LOAD/JPZ 4.
- Each d_ready-low cycle in LOAD_A/STORE adds one cycle. d_ready is ignored in all other states.
- go is sampled only in HALT and PAUSE. A go held high in PAUSE executes one instruction per pass.
- step_mode is sampled at the exit of the final execute state.

## Test plan
- Reset: reset_n=0 mid-ADD → same cycle state_o=0, pc_clr=1, rf_w_wr=0. Release → pc_clr high for 2 cycles, then ld=pc_up=1.
- LOAD 0x2_A5_3 with d_ready low for 2 cycles → d_rd=1 and d_addr=0xA5 for 3 cycles, then one cycle of rf_s=1, rf_w_wr=1, rf_w_addr=3.
- ADD 0x3_124_0 → rf_ra_addr=1, rf_rb_addr=2, rf_w_addr=4, alu_s0=1 for exactly one cycle. SUB is identical with alu_s0=2.
- JPZ 0x7_5_3C_0: alu_zero=1 → pc_load=1, pc_target=0x3C. alu_zero=0 → pc_load stays 0 and next FETCH increments.
- LDI 0x6_7F_9 → rf_s=2, rf_imm=0x7F, rf_w_addr=9. Then step_mode=1 → PAUSE (13) until go; go → FETCH.
- HALT then go → FETCH resumes. Opcode 0xA → ERROR (14), err=1; go ignored; only reset_n clears it.
